// File: rtl/spi16_master.sv
// SPI mode 0 master, one 16-bit MSB-first frame per accepted start.
// Chip-select setup, hold and inter-frame gap are parameterised in clk cycles.
//
// Handshake: start is a level request sampled only in IDLE; the frame is
// accepted at the first rising clk edge where state is IDLE and start=1.
// start is ignored (not queued) in every other state. done is a one-cycle
// pulse coinciding with nSS rising and dout being loaded.
module spi16_master #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        start,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy,
  output logic        done,
  output logic        nSS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Terminal counts: every timed interval counts 0..N-1 in the phase counter.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] dout_q, dout_d;
  logic        sclk_q, sclk_d;
  logic        nss_q, nss_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      phase_q <= 8'd0;
      bit_q   <= 5'd0;
      tx_q    <= 16'h0000;
      rx_q    <= 16'h0000;
      dout_q  <= 16'h0000;
      sclk_q  <= 1'b0;
      nss_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      nss_q   <= nss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    nss_d   = nss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d    = din;
          rx_d    = 16'h0000;
          nss_d   = 1'b0;
          busy_d  = 1'b1;
          phase_d = 8'd0;
          bit_d   = 5'd0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d = 8'd0;
          state_d = ST_SHIFT;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      ST_SHIFT: begin
        if (phase_q == DIV_LAST) begin
          phase_d = 8'd0;
          if (!sclk_q) begin
            // End of low phase: raise SCLK and capture MISO at the same edge.
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], MISO};
          end else begin
            // End of high phase: drop SCLK; MOSI advances except after bit 16.
            sclk_d = 1'b0;
            if (bit_q == 5'd15) begin
              bit_d   = 5'd16;
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + 5'd1;
              tx_d  = {tx_q[14:0], 1'b0};
            end
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      ST_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = 8'd0;
          nss_d   = 1'b1;
          done_d  = 1'b1;
          dout_d  = rx_q;
          state_d = ST_GAP;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = 8'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs come straight from flops; MOSI is the tx register MSB.
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nSS       = nss_q;
  assign SCLK      = sclk_q;
  assign MOSI      = tx_q[15];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi16_master.sv
// Directed + randomized bench for spi16_master: loopback, stuck MISO,
// ignored start, back-to-back frames at CLK_DIV=1, reset abort, slave model.
module tb_spi16_master;

  logic        clk;
  logic        res_n;
  logic        start;
  logic [15:0] din;
  logic [15:0] dout;
  logic        busy, done, nss, sclk, mosi, miso;
  logic [2:0]  dbg_state;

  logic        start1;
  logic [15:0] din1;
  logic [15:0] dout1;
  logic        busy1, done1, nss1, sclk1, mosi1;
  logic [2:0]  dbg_state1;

  int vectors = 0;
  int miscompares = 0;

  // MISO source: 0 = loopback, 1 = tied high, 2 = behavioural slave
  int miso_mode = 0;

  // Behavioural mode-0 slave: presents word MSB first, advances on each SCLK fall
  logic [15:0] slv_word = 16'h0000;
  logic [15:0] slv_rx   = 16'h0000;
  int          slv_falls = 0;
  logic        slv_miso;

  logic [15:0] exp_q[$];

  spi16_master dut (
    .clk(clk), .res_n(res_n), .start(start), .din(din), .dout(dout),
    .busy(busy), .done(done), .nSS(nss), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso), .dbg_state(dbg_state)
  );

  spi16_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .res_n(res_n), .start(start1), .din(din1), .dout(dout1),
    .busy(busy1), .done(done1), .nSS(nss1), .SCLK(sclk1), .MOSI(mosi1),
    .MISO(mosi1), .dbg_state(dbg_state1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign slv_miso = (slv_falls < 16) ? slv_word[4'(15 - slv_falls)] : 1'b0;
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : slv_miso;

  always @(negedge sclk or posedge nss) begin
    if (nss) slv_falls = 0;
    else     slv_falls = slv_falls + 1;
  end

  always @(posedge sclk) begin
    if (!nss) slv_rx = {slv_rx[14:0], mosi};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one frame from IDLE, sampling on falling clk edges; optionally
  // re-pulse start with din=1234 inject_at samples after acceptance.
  task automatic do_frame(input logic [15:0] word, input int inject_at,
                          output int low_cnt, output int rises, output int dones,
                          output int misaligned, output int mosi_high, output int timeout);
    logic prev_sclk, prev_nss;
    low_cnt = 0; rises = 0; dones = 0; misaligned = 0; mosi_high = 0; timeout = 1;
    prev_sclk = 1'b0; prev_nss = 1'b1;
    @(negedge clk);
    din = word;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!nss) low_cnt++;
      if (!nss && mosi) mosi_high++;
      if (sclk && !prev_sclk) rises++;
      if (done) begin
        dones++;
        if (!(nss && !prev_nss)) misaligned++;
      end
      prev_sclk = sclk;
      prev_nss  = nss;
      if (!busy) begin
        timeout = 0;
        break;
      end
      if (cyc == inject_at) begin
        din = 16'h1234;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  localparam int FRAME_LOW = 2 + 32 * 2 + 2;

  initial begin
    int low_cnt, rises, dones, misaligned, mosi_high, timeout;
    int run, started, n_done1, bad_dout1;
    logic prev1;
    int low_q[$];
    int high_q[$];
    logic [15:0] w, exp_rx, exp_dout;

    res_n = 1'b0; start = 1'b0; din = 16'h0000;
    start1 = 1'b0; din1 = 16'h8001;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_nss", {31'd0, nss}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'h0);
    chk("rst_dout1", {16'd0, dout1}, 32'h0);
    res_n = 1'b1;
    start1 = 1'b1;
    @(negedge clk);

    // Loopback A53C
    miso_mode = 0;
    do_frame(16'hA53C, -1, low_cnt, rises, dones, misaligned, mosi_high, timeout);
    chk("lb_timeout", timeout, 0);
    chk("lb_nss_low", low_cnt, FRAME_LOW);
    chk("lb_rises", rises, 16);
    chk("lb_dones", dones, 1);
    chk("lb_done_align", misaligned, 0);
    chk("lb_dout", {16'd0, dout}, 32'hA53C);

    // MISO tied high, din zero
    miso_mode = 1;
    do_frame(16'h0000, -1, low_cnt, rises, dones, misaligned, mosi_high, timeout);
    chk("one_timeout", timeout, 0);
    chk("one_dout", {16'd0, dout}, 32'hFFFF);
    chk("one_mosi_low", mosi_high, 0);
    chk("one_dones", dones, 1);

    // Second start mid-frame is ignored
    miso_mode = 0;
    do_frame(16'h5AC3, 9, low_cnt, rises, dones, misaligned, mosi_high, timeout);
    chk("ign_timeout", timeout, 0);
    chk("ign_dones", dones, 1);
    chk("ign_nss_low", low_cnt, FRAME_LOW);
    chk("ign_dout", {16'd0, dout}, 32'h5AC3);
    // No frame should start afterwards from the stray request
    repeat (5) @(negedge clk);
    chk("ign_idle_nss", {31'd0, nss}, 32'd1);
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames on the CLK_DIV=1 instance with start held
    run = 0; started = 0; n_done1 = 0; bad_dout1 = 0;
    prev1 = nss1;
    for (int cyc = 0; cyc < 250; cyc++) begin
      @(negedge clk);
      if (nss1 != prev1) begin
        if (started != 0) begin
          if (prev1 == 1'b0) low_q.push_back(run);
          else               high_q.push_back(run);
        end
        started = 1;
        run = 1;
      end else begin
        run++;
      end
      if (done1) begin
        n_done1++;
        if (dout1 !== 16'h8001) bad_dout1++;
      end
      prev1 = nss1;
    end
    chk("b2b_frames", {31'd0, low_q.size() >= 3}, 32'd1);
    chk("b2b_gaps", {31'd0, high_q.size() >= 3}, 32'd1);
    foreach (low_q[i])  chk("b2b_low_len", low_q[i], 36);
    foreach (high_q[i]) chk("b2b_high_len", high_q[i], 3);
    chk("b2b_dout_bad", bad_dout1, 0);
    chk("b2b_dones", {31'd0, n_done1 >= 5}, 32'd1);

    // Reset mid-frame after 8 SCLK rising edges
    miso_mode = 0;
    @(negedge clk);
    din = 16'hC3C3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; timeout = 1;
    begin
      logic ps;
      ps = sclk;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (sclk && !ps) rises++;
        ps = sclk;
        if (rises == 8) begin
          timeout = 0;
          break;
        end
        @(negedge clk);
      end
    end
    chk("rstm_timeout", timeout, 0);
    #2;
    res_n = 1'b0;
    #1;
    chk("rstm_nss", {31'd0, nss}, 32'd1);
    chk("rstm_sclk", {31'd0, sclk}, 32'd0);
    chk("rstm_busy", {31'd0, busy}, 32'd0);
    chk("rstm_dout", {16'd0, dout}, 32'h0);
    dones = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rstm_no_done", dones, 0);
    res_n = 1'b1;
    start1 = 1'b0;
    do_frame(16'h0FF0, -1, low_cnt, rises, dones, misaligned, mosi_high, timeout);
    chk("rstm_next_timeout", timeout, 0);
    chk("rstm_next_low", low_cnt, FRAME_LOW);
    chk("rstm_next_dout", {16'd0, dout}, 32'h0FF0);

    // Random words against the slave model
    miso_mode = 2;
    for (int i = 0; i < 100; i++) begin
      w = 16'($urandom);
      slv_word = 16'($urandom_range(0, 65535));
      exp_q.push_back(w);
      exp_q.push_back(slv_word);
      do_frame(w, -1, low_cnt, rises, dones, misaligned, mosi_high, timeout);
      exp_rx   = exp_q.pop_front();
      exp_dout = exp_q.pop_front();
      chk("slv_timeout", timeout, 0);
      chk("slv_rx", {16'd0, slv_rx}, {16'd0, exp_rx});
      chk("slv_dout", {16'd0, dout}, {16'd0, exp_dout});
      chk("slv_dones", dones, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi16_master.md
SPI16_MASTER -- requirements
Module: spi16_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter CS_SETUP, default 2: clk cycles from nSS falling to the first SCLK low phase; legal range 1..255.
REQ-003 SHALL have parameter CS_HOLD, default 2: clk cycles from the last SCLK falling edge to nSS rising; legal range 1..255.
REQ-004 SHALL have parameter CS_GAP, default 2: minimum clk cycles spent in GAP after nSS rises; legal range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on the rising edge.
REQ-006 SHALL have port res_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: request one 16-bit frame.
REQ-008 SHALL have port din, input, 16 bits: transmit word, sampled when start is accepted.
REQ-009 SHALL have port dout, output, 16 bits: last received word.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame or gap is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-012 SHALL have port nSS, output, 1 bit: slave select, active-low.
REQ-013 SHALL have ports SCLK (output, 1 bit), MOSI (output, 1 bit) and MISO (input, 1 bit): serial clock, master data out and master data in.

Function
REQ-014 SHALL use SPI mode 0, MSB first: SCLK idles low, MOSI is stable across each SCLK rising edge, and the slave shifts on falling edges, compatible with spi16.
REQ-015 SHALL implement the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-016 SHALL, in IDLE, accept start=1 at a clk edge, and at that same edge: latch din into the tx shift register; drive nSS=0, busy=1 and MOSI=din[15]; enter SETUP.
REQ-017 SHALL ignore start in every state other than IDLE; no queuing and no effect on the current frame.
REQ-018 SHALL stay in SETUP for exactly CS_SETUP cycles with SCLK=0, then enter SHIFT.
REQ-019 SHALL, in SHIFT, transfer each of 16 bits as an SCLK low phase of CLK_DIV cycles followed by an SCLK high phase of CLK_DIV cycles.
REQ-020 SHALL sample MISO into the rx shift register (LSB-in, shifting left) at the clk edge that drives SCLK from 0 to 1.
REQ-021 SHALL advance MOSI to the next tx bit at the clk edge that drives SCLK from 1 to 0, for bits 1..15 only.
REQ-022 SHALL hold MOSI unchanged after bit 16.
REQ-023 SHALL use a 5-bit bit counter (0..16) and an 8-bit phase counter.
REQ-024 SHALL drive SCLK low and enter HOLD at the clk edge that ends the 16th high phase.
REQ-025 SHALL stay in HOLD for CS_HOLD cycles with nSS=0 and SCLK=0.
REQ-026 SHALL total exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles of nSS low per frame (68 with defaults).
REQ-027 SHALL, at the edge leaving HOLD: set nSS=1, pulse done=1 for exactly one cycle, load dout with the 16 received bits, and enter GAP.
REQ-028 SHALL keep dout stable until the next done pulse.
REQ-029 SHALL keep busy=1 and nSS=1 in GAP for CS_GAP cycles, then enter IDLE with busy=0.
REQ-030 SHALL, if start is held high continuously, hold nSS high for exactly CS_GAP+1 cycles between frames.
REQ-031 SHALL drive SCLK, nSS, MOSI, busy and done from registers only, with no combinational path from any input to any output.

Reset
REQ-032 SHALL, while res_n=0, hold nSS=1, SCLK=0, MOSI=0, busy=0, done=0 and dout=16'h0000 in state IDLE, with all counters and shift registers cleared.
REQ-033 SHALL, on res_n assertion mid-frame, abort the frame immediately (asynchronously) with no done pulse and no dout update.
REQ-034 SHALL, after res_n deasserts, accept start no earlier than the first clk edge at which res_n is high.

Verification
REQ-035 Loopback (MISO tied to MOSI), din=16'hA53C, one start pulse, defaults -> nSS low for 68 cycles, 16 SCLK rising edges, done pulse in the cycle nSS rises, dout=16'hA53C.
REQ-036 MISO tied 1, din=16'h0000 -> dout=16'hFFFF; MOSI=0 throughout the frame.
REQ-037 start pulsed again 10 cycles into a frame with din=16'h1234 -> ignored; only one done pulse; loopback dout equals the first din.
REQ-038 start held high, CLK_DIV=1, loopback, din=16'h8001 -> frames of 36 nSS-low cycles separated by exactly 3 nSS-high cycles; each frame returns dout=16'h8001.
REQ-039 res_n pulsed low after 8 SCLK rising edges -> nSS=1, SCLK=0, busy=0 and dout=16'h0000 immediately; no done pulse; the next frame completes normally.
REQ-040 Slave-model check, comparing against a spi16 instance in simulation -> the slave's received word equals din, and dout equals the slave's din, for 100 random words.
